// File: rtl/surf_axil_master.sv
// surf_axil_master: converts a simple command/response handshake into single
// AXI4-Lite transactions. Only one transaction is outstanding at a time.
// Bus statistics are kept in three counters.
module surf_axil_master #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 7
) (
  input  logic                                clk,
  input  logic                                rst,
  // command side
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic                                rsp_write,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  // AXI4-Lite master
  output logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  output logic [2:0]                          s00_axi_awprot,
  output logic                                s00_axi_awvalid,
  input  logic                                s00_axi_awready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  output logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  output logic                                s00_axi_wvalid,
  input  logic                                s00_axi_wready,
  input  logic [1:0]                          s00_axi_bresp,
  input  logic                                s00_axi_bvalid,
  output logic                                s00_axi_bready,
  output logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  output logic [2:0]                          s00_axi_arprot,
  output logic                                s00_axi_arvalid,
  input  logic                                s00_axi_arready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  input  logic [1:0]                          s00_axi_rresp,
  input  logic                                s00_axi_rvalid,
  output logic                                s00_axi_rready,
  // statistics
  output logic [15:0]                         wr_count,
  output logic [15:0]                         rd_count,
  output logic [15:0]                         err_count
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int DW = C_S00_AXI_DATA_WIDTH;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_AW_W = 3'd1;
  localparam logic [2:0] WR_B    = 3'd2;
  localparam logic [2:0] RD_AR   = 3'd3;
  localparam logic [2:0] RD_R    = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]      state_q,     state_d;
  logic [AW-1:0]   addr_q,      addr_d;
  logic [DW-1:0]   wData_q,     wData_d;
  logic [DW/8-1:0] wStrb_q,     wStrb_d;
  logic            awValid_q,   awValid_d;
  logic            wValid_q,    wValid_d;
  logic            arValid_q,   arValid_d;
  logic            bReady_q,    bReady_d;
  logic            rReady_q,    rReady_d;
  logic            rspWrite_q,  rspWrite_d;
  logic [DW-1:0]   rspRdata_q,  rspRdata_d;
  logic [1:0]      rspResp_q,   rspResp_d;
  logic [15:0]     wrCount_q,   wrCount_d;
  logic [15:0]     rdCount_q,   rdCount_d;
  logic [15:0]     errCount_q,  errCount_d;

  logic awDone;
  logic wDone;

  // Next-state logic: sequences one AXI-Lite transaction per accepted command
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wData_d    = wData_q;
    wStrb_d    = wStrb_q;
    awValid_d  = awValid_q;
    wValid_d   = wValid_q;
    arValid_d  = arValid_q;
    bReady_d   = bReady_q;
    rReady_d   = rReady_q;
    rspWrite_d = rspWrite_q;
    rspRdata_d = rspRdata_q;
    rspResp_d  = rspResp_q;
    wrCount_d  = wrCount_q;
    rdCount_d  = rdCount_q;
    errCount_d = errCount_q;
    awDone     = !awValid_q || s00_axi_awready;
    wDone      = !wValid_q || s00_axi_wready;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[AW-1:2], 2'b00};
          wData_d = cmd_wdata;
          wStrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = WR_AW_W;
            awValid_d = 1'b1;
            wValid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arValid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        if (s00_axi_awready) awValid_d = 1'b0;
        if (s00_axi_wready)  wValid_d  = 1'b0;
        if (awDone && wDone) begin
          state_d  = WR_B;
          bReady_d = 1'b1;
        end
      end
      WR_B: begin
        if (s00_axi_bvalid) begin
          state_d    = RSP;
          bReady_d   = 1'b0;
          rspWrite_d = 1'b1;
          rspRdata_d = '0;
          rspResp_d  = s00_axi_bresp;
          wrCount_d  = wrCount_q + 16'd1;
          if (s00_axi_bresp != 2'b00 && errCount_q != 16'hFFFF)
            errCount_d = errCount_q + 16'd1;
        end
      end
      RD_AR: begin
        if (s00_axi_arready) begin
          state_d   = RD_R;
          arValid_d = 1'b0;
          rReady_d  = 1'b1;
        end
      end
      RD_R: begin
        if (s00_axi_rvalid) begin
          state_d    = RSP;
          rReady_d   = 1'b0;
          rspWrite_d = 1'b0;
          rspRdata_d = s00_axi_rdata;
          rspResp_d  = s00_axi_rresp;
          rdCount_d  = rdCount_q + 16'd1;
          if (s00_axi_rresp != 2'b00 && errCount_q != 16'hFFFF)
            errCount_d = errCount_q + 16'd1;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that also aborts any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wData_q    <= '0;
      wStrb_q    <= '0;
      awValid_q  <= 1'b0;
      wValid_q   <= 1'b0;
      arValid_q  <= 1'b0;
      bReady_q   <= 1'b0;
      rReady_q   <= 1'b0;
      rspWrite_q <= 1'b0;
      rspRdata_q <= '0;
      rspResp_q  <= 2'b00;
      wrCount_q  <= '0;
      rdCount_q  <= '0;
      errCount_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wData_q    <= wData_d;
      wStrb_q    <= wStrb_d;
      awValid_q  <= awValid_d;
      wValid_q   <= wValid_d;
      arValid_q  <= arValid_d;
      bReady_q   <= bReady_d;
      rReady_q   <= rReady_d;
      rspWrite_q <= rspWrite_d;
      rspRdata_q <= rspRdata_d;
      rspResp_q  <= rspResp_d;
      wrCount_q  <= wrCount_d;
      rdCount_q  <= rdCount_d;
      errCount_q <= errCount_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign rsp_valid       = (state_q == RSP);
  assign rsp_write       = rspWrite_q;
  assign rsp_rdata       = rspRdata_q;
  assign rsp_resp        = rspResp_q;

  assign s00_axi_awaddr  = addr_q;
  assign s00_axi_awprot  = 3'b000;
  assign s00_axi_awvalid = awValid_q;
  assign s00_axi_wdata   = wData_q;
  assign s00_axi_wstrb   = wStrb_q;
  assign s00_axi_wvalid  = wValid_q;
  assign s00_axi_bready  = bReady_q;
  assign s00_axi_araddr  = addr_q;
  assign s00_axi_arprot  = 3'b000;
  assign s00_axi_arvalid = arValid_q;
  assign s00_axi_rready  = rReady_q;

  assign wr_count        = wrCount_q;
  assign rd_count        = rdCount_q;
  assign err_count       = errCount_q;

endmodule

// File: tb/tb_surf_axil_master.sv
// tb_surf_axil_master: directed test of the AXI-Lite command master against a
// cycle-stepped slave model with configurable handshake delays.
module tb_surf_axil_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  s00_axi_awaddr, s00_axi_araddr;
  logic [2:0]  s00_axi_awprot, s00_axi_arprot;
  logic        s00_axi_awvalid, s00_axi_awready;
  logic [31:0] s00_axi_wdata;
  logic [3:0]  s00_axi_wstrb;
  logic        s00_axi_wvalid, s00_axi_wready;
  logic [1:0]  s00_axi_bresp;
  logic        s00_axi_bvalid, s00_axi_bready;
  logic        s00_axi_arvalid, s00_axi_arready;
  logic [31:0] s00_axi_rdata;
  logic [1:0]  s00_axi_rresp;
  logic        s00_axi_rvalid, s00_axi_rready;
  logic [15:0] wr_count, rd_count, err_count;

  int checks = 0;
  int errors = 0;

  // slave model configuration and observations
  int          awDelay, wDelay, bDelay, arDelay, rDelay;
  logic [1:0]  slvResp;
  logic [31:0] slvRdata;
  int          protoErr, bHs, rHs;
  logic        sawWFirst;
  int          lat;

  surf_axil_master #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
    .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
    .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid),
    .s00_axi_bready(s00_axi_bready),
    .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
    .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
    .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  // free-running clock
  always #5 clk = ~clk;

  // hard stop in case something stalls outside a bounded loop
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic slaveIdle();
    s00_axi_awready = 1'b0; s00_axi_wready = 1'b0;
    s00_axi_bvalid  = 1'b0; s00_axi_bresp  = 2'b00;
    s00_axi_arready = 1'b0; s00_axi_rvalid = 1'b0;
    s00_axi_rdata   = '0;   s00_axi_rresp  = 2'b00;
  endtask

  // presents one command for exactly one accepting edge; returns at the
  // falling edge of the first cycle after acceptance
  task automatic applyStimulus(input logic wr, input logic [6:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    checkOutput("cmdReadyIdle", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // steps the slave one cycle per falling edge until rsp_valid appears;
  // latency is the cycle index with the accept cycle counted as 0
  task automatic runSlave(input logic isWrite, output int latency);
    logic awDone = 1'b0, wDone = 1'b0, arDone = 1'b0;
    int awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
    latency = -1;
    protoErr = 0; bHs = 0; rHs = 0; sawWFirst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (rsp_valid) begin
        latency = i;
        break;
      end
      s00_axi_bvalid = 1'b0;
      s00_axi_rvalid = 1'b0;
      if (isWrite) begin
        if (s00_axi_arvalid || s00_axi_rready) protoErr++;
        if (s00_axi_bready && !(awDone && wDone)) protoErr++;
        if (awDone && s00_axi_awvalid) protoErr++;
        if (wDone && s00_axi_wvalid) protoErr++;
        if (wDone && !awDone && !s00_axi_wvalid && s00_axi_awvalid) sawWFirst = 1'b1;
        if (awDone && wDone && s00_axi_bready) begin
          if (bCnt >= bDelay) begin
            s00_axi_bvalid = 1'b1; s00_axi_bresp = slvResp; bHs++;
          end else bCnt++;
        end
        s00_axi_awready = 1'b0;
        if (!awDone) begin
          if (!s00_axi_awvalid) protoErr++;
          if (awCnt >= awDelay) begin s00_axi_awready = 1'b1; awDone = 1'b1; end
          else awCnt++;
        end
        s00_axi_wready = 1'b0;
        if (!wDone) begin
          if (!s00_axi_wvalid) protoErr++;
          if (wCnt >= wDelay) begin s00_axi_wready = 1'b1; wDone = 1'b1; end
          else wCnt++;
        end
      end else begin
        if (s00_axi_awvalid || s00_axi_wvalid || s00_axi_bready) protoErr++;
        if (arDone && s00_axi_arvalid) protoErr++;
        if (s00_axi_rready && !arDone) protoErr++;
        if (arDone && s00_axi_rready) begin
          if (rCnt >= rDelay) begin
            s00_axi_rvalid = 1'b1; s00_axi_rdata = slvRdata; s00_axi_rresp = slvResp; rHs++;
          end else rCnt++;
        end
        s00_axi_arready = 1'b0;
        if (!arDone) begin
          if (!s00_axi_arvalid) protoErr++;
          if (arCnt >= arDelay) begin s00_axi_arready = 1'b1; arDone = 1'b1; end
          else arCnt++;
        end
      end
      @(negedge clk);
    end
    slaveIdle();
  endtask

  // checks response fields, holds rsp_ready low, then consumes the response
  task automatic consumeRsp(input string tag, input int hold, input logic expWrite,
                            input logic [31:0] expRdata, input logic [1:0] expResp);
    int bad = 0;
    checkOutput({tag, "_rspWrite"}, {31'd0, rsp_write}, {31'd0, expWrite});
    checkOutput({tag, "_rspRdata"}, rsp_rdata, expRdata);
    checkOutput({tag, "_rspResp"},  {30'd0, rsp_resp}, {30'd0, expResp});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_write !== expWrite || rsp_rdata !== expRdata || rsp_resp !== expResp) bad++;
      if (cmd_ready) bad++;
      if (s00_axi_awvalid || s00_axi_wvalid || s00_axi_arvalid || s00_axi_bready || s00_axi_rready) bad++;
    end
    checkOutput({tag, "_holdStable"}, bad, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_rspCleared"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_backIdle"},   {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic setDelays(input int aw, input int w, input int b, input int ar, input int r);
    awDelay = aw; wDelay = w; bDelay = b; arDelay = ar; rDelay = r;
  endtask

  // directed sequence
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    slaveIdle();
    slvResp = 2'b00; slvRdata = '0;
    setDelays(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    checkOutput("rstCmdReady", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rstValids", {27'd0, s00_axi_awvalid, s00_axi_wvalid, s00_axi_arvalid,
                              s00_axi_bready, s00_axi_rready}, 32'd0);
    checkOutput("rstAddrData", {s00_axi_awaddr, 25'd0} | s00_axi_wdata, 32'd0);
    checkOutput("rstCounters", {wr_count, rd_count | err_count}, 32'd0);

    // zero-wait write
    applyStimulus(1'b1, 7'h08, 32'hDEADBEEF, 4'hF);
    checkOutput("wr1Awaddr", {25'd0, s00_axi_awaddr}, 32'h08);
    checkOutput("wr1Wdata", s00_axi_wdata, 32'hDEADBEEF);
    checkOutput("wr1Wstrb", {28'd0, s00_axi_wstrb}, 32'hF);
    checkOutput("wr1Prot", {26'd0, s00_axi_awprot, s00_axi_arprot}, 32'd0);
    checkOutput("wr1Valids", {30'd0, s00_axi_awvalid, s00_axi_wvalid}, 32'd3);
    checkOutput("wr1CmdBusy", {31'd0, cmd_ready}, 32'd0);
    runSlave(1'b1, lat);
    checkOutput("wr1Latency", lat, 32'd3);
    checkOutput("wr1Proto", protoErr, 32'd0);
    consumeRsp("wr1", 0, 1'b1, 32'd0, 2'b00);
    checkOutput("wr1Count", {16'd0, wr_count}, 32'd1);

    // write where W completes four cycles before AW
    setDelays(4, 0, 0, 0, 0);
    applyStimulus(1'b1, 7'h24, 32'hA5A5_0F0F, 4'hC);
    runSlave(1'b1, lat);
    checkOutput("wr2Latency", lat, 32'd7);
    checkOutput("wr2WFirst", {31'd0, sawWFirst}, 32'd1);
    checkOutput("wr2Proto", protoErr, 32'd0);
    checkOutput("wr2OneB", bHs, 32'd1);
    consumeRsp("wr2", 0, 1'b1, 32'd0, 2'b00);
    checkOutput("wr2Count", {16'd0, wr_count}, 32'd2);

    // read from unaligned address with delayed rvalid; response held 5 cycles
    setDelays(0, 0, 0, 0, 2);
    slvRdata = 32'h12345678; slvResp = 2'b00;
    applyStimulus(1'b0, 7'h13, 32'h0, 4'h0);
    checkOutput("rd1Araddr", {25'd0, s00_axi_araddr}, 32'h10);
    checkOutput("rd1Arvalid", {31'd0, s00_axi_arvalid}, 32'd1);
    runSlave(1'b0, lat);
    checkOutput("rd1Latency", lat, 32'd5);
    checkOutput("rd1Proto", protoErr, 32'd0);
    consumeRsp("rd1", 5, 1'b0, 32'h12345678, 2'b00);
    checkOutput("rd1Counts", {rd_count, err_count}, {16'd1, 16'd0});

    // read returning SLVERR, zero-wait
    setDelays(0, 0, 0, 0, 0);
    slvRdata = 32'h0BAD_F00D; slvResp = 2'b10;
    applyStimulus(1'b0, 7'h40, 32'h0, 4'h0);
    runSlave(1'b0, lat);
    checkOutput("rd2Latency", lat, 32'd3);
    consumeRsp("rd2", 1, 1'b0, 32'h0BAD_F00D, 2'b10);
    checkOutput("rd2Counts", {rd_count, err_count}, {16'd2, 16'd1});

    // write returning DECERR; read data must not leak into the write response
    slvResp = 2'b11;
    setDelays(1, 2, 1, 0, 0);
    applyStimulus(1'b1, 7'h2E, 32'h0000_BEEF, 4'h3);
    checkOutput("wr3Awaddr", {25'd0, s00_axi_awaddr}, 32'h2C);
    runSlave(1'b1, lat);
    checkOutput("wr3Proto", protoErr, 32'd0);
    consumeRsp("wr3", 0, 1'b1, 32'd0, 2'b11);
    checkOutput("wr3Counts", {wr_count, err_count}, {16'd3, 16'd2});

    // error counter saturation: preload near the top, then two error reads
    @(negedge clk);
    force dut.errCount_q = 16'hFFFE;
    #1;
    release dut.errCount_q;
    slvResp = 2'b10; slvRdata = 32'h1;
    setDelays(0, 0, 0, 0, 0);
    applyStimulus(1'b0, 7'h00, 32'h0, 4'h0);
    runSlave(1'b0, lat);
    consumeRsp("sat1", 0, 1'b0, 32'h1, 2'b10);
    checkOutput("sat1Err", {16'd0, err_count}, 32'hFFFF);
    applyStimulus(1'b0, 7'h04, 32'h0, 4'h0);
    runSlave(1'b0, lat);
    consumeRsp("sat2", 0, 1'b0, 32'h1, 2'b10);
    checkOutput("sat2Err", {16'd0, err_count}, 32'hFFFF);
    checkOutput("sat2Rd", {16'd0, rd_count}, 32'd4);

    // reset while waiting in WR_B aborts the transaction
    applyStimulus(1'b1, 7'h10, 32'hCAFE_0001, 4'hF);
    s00_axi_awready = 1'b1; s00_axi_wready = 1'b1;
    @(negedge clk);
    slaveIdle();
    checkOutput("abortInWrB", {31'd0, s00_axi_bready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortValids", {26'd0, s00_axi_awvalid, s00_axi_wvalid, s00_axi_arvalid,
                                s00_axi_bready, s00_axi_rready, rsp_valid}, 32'd0);
    checkOutput("abortIdle", {31'd0, cmd_ready}, 32'd1);
    checkOutput("abortCounters", {wr_count, rd_count | err_count}, 32'd0);
    begin
      int stray = 0;
      s00_axi_bvalid = 1'b1; s00_axi_bresp = 2'b10;
      s00_axi_rvalid = 1'b1; s00_axi_rresp = 2'b10;
      repeat (3) begin
        @(negedge clk);
        if (rsp_valid || !cmd_ready || s00_axi_bready || s00_axi_rready) stray++;
        if (wr_count != 16'd0 || rd_count != 16'd0 || err_count != 16'd0) stray++;
      end
      slaveIdle();
      checkOutput("strayIgnored", stray, 32'd0);
    end

    // recovery write after the abort
    slvResp = 2'b00;
    applyStimulus(1'b1, 7'h7F, 32'h5555_AAAA, 4'h5);
    checkOutput("wr4Awaddr", {25'd0, s00_axi_awaddr}, 32'h7C);
    runSlave(1'b1, lat);
    checkOutput("wr4Latency", lat, 32'd3);
    consumeRsp("wr4", 2, 1'b1, 32'd0, 2'b00);
    checkOutput("wr4Count", {16'd0, wr_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
